// File: rtl/cnn_pkg.sv
// Shared CNN datapath constants and types used by the DMA block fetcher.
package cnn_pkg;

    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned ADDR_WIDTH = 16;
    localparam int unsigned BLOCK_SIZE = 25;
    localparam int unsigned IDX_WIDTH  = $clog2(BLOCK_SIZE);
    localparam int unsigned SUM_WIDTH  = DATA_WIDTH + 5;
    localparam int unsigned LAT_WIDTH  = 3;

    typedef logic signed [DATA_WIDTH-1:0]      data_t;
    typedef logic [ADDR_WIDTH-1:0]             addr_t;
    typedef logic [DATA_WIDTH*BLOCK_SIZE-1:0]  block_t;
    typedef logic [IDX_WIDTH-1:0]              idx_t;
    typedef logic [LAT_WIDTH-1:0]              lat_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_STREAM,
        ST_DONE
    } fetch_state_e;

    // Extract word i of a packed DMA block (word 0 in the LSBs).
    function automatic data_t block_word(input block_t blk, input int unsigned i);
        return data_t'(blk[i*DATA_WIDTH +: DATA_WIDTH]);
    endfunction

endpackage

// File: rtl/dma_block_fetcher_if.sv
// DMA block-read port plus the streaming valid/ready port of the block fetcher.
interface dma_block_fetcher_if;
    import cnn_pkg::*;

    logic   dma_enable;
    logic   dma_rw;
    addr_t  dma_address;
    block_t dma_block;
    data_t  out_data;
    logic   out_valid;
    logic   out_ready;
    logic   out_last;

    modport master (
        output dma_enable, dma_rw, dma_address, out_data, out_valid, out_last,
        input  dma_block, out_ready
    );

    modport slave (
        input  dma_enable, dma_rw, dma_address, out_data, out_valid, out_last,
        output dma_block, out_ready
    );

endinterface

// File: rtl/dma_block_fetcher_block_capture_buf.sv
// BLOCK_SIZE x DATA_WIDTH register file: parallel load of a whole DMA block, indexed read.
module block_capture_buf
    import cnn_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  block_t load_data,
    input  idx_t   rd_idx,
    output data_t  rd_data_c
);

    data_t mem [BLOCK_SIZE];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < BLOCK_SIZE; i++) mem[i] <= '0;
        end else if (load) begin
            for (int unsigned i = 0; i < BLOCK_SIZE; i++) mem[i] <= block_word(load_data, i);
        end
    end

    // Indices past the block read as zero so the look-ahead index never aliases.
    assign rd_data_c = (32'(rd_idx) < BLOCK_SIZE) ? mem[rd_idx] : '0;

endmodule

// File: rtl/dma_block_fetcher.sv
// Fetches one 5x5 block over the DMA read port and streams it word by word to the PE.
// Optional block_sum accumulator enabled by defining DMA_BLOCK_FETCHER_SUM_EN.
module dma_block_fetcher
    import cnn_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  start,
    input  addr_t base_addr,
    output logic  busy,
    output logic  done,
`ifdef DMA_BLOCK_FETCHER_SUM_EN
    output logic signed [SUM_WIDTH-1:0] block_sum,
`endif
    dma_block_fetcher_if.master bus
);

    localparam idx_t LAST_IDX = idx_t'(BLOCK_SIZE - 1);

    fetch_state_e state;
    lat_t         lat_cnt;
    idx_t         idx;
    idx_t         nxt_idx_c;
    logic         cap_load_c;
    data_t        buf_data_c;

    assign nxt_idx_c  = idx + idx_t'(1);
    assign cap_load_c = (state == ST_WAIT) && (lat_cnt == lat_t'(1));

    block_capture_buf u_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (cap_load_c),
        .load_data (bus.dma_block),
        .rd_idx    (nxt_idx_c),
        .rd_data_c (buf_data_c)
    );

    // out_data is pre-loaded with the next word so a held-high ready streams without bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            lat_cnt         <= '0;
            idx             <= '0;
            bus.dma_enable  <= 1'b0;
            bus.dma_rw      <= 1'b0;
            bus.dma_address <= '0;
            bus.out_data    <= '0;
            bus.out_valid   <= 1'b0;
            bus.out_last    <= 1'b0;
`ifdef DMA_BLOCK_FETCHER_SUM_EN
            block_sum       <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        bus.dma_address <= base_addr;
                        bus.dma_rw      <= 1'b1;
                        bus.dma_enable  <= 1'b1;
                        busy            <= 1'b1;
                        state           <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    bus.dma_enable <= 1'b0;
                    lat_cnt        <= lat_t'(READ_LATENCY);
                    state          <= ST_WAIT;
                end
                ST_WAIT: begin
                    lat_cnt <= lat_cnt - lat_t'(1);
                    if (cap_load_c) begin
                        idx           <= '0;
                        bus.out_data  <= block_word(bus.dma_block, 0);
                        bus.out_last  <= (LAST_IDX == idx_t'(0));
                        bus.out_valid <= 1'b1;
`ifdef DMA_BLOCK_FETCHER_SUM_EN
                        block_sum     <= '0;
`endif
                        state         <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (bus.out_valid && bus.out_ready) begin
`ifdef DMA_BLOCK_FETCHER_SUM_EN
                        block_sum <= block_sum + SUM_WIDTH'(bus.out_data);
`endif
                        if (idx == LAST_IDX) begin
                            bus.out_valid <= 1'b0;
                            bus.out_last  <= 1'b0;
                            done          <= 1'b1;
                            state         <= ST_DONE;
                        end else begin
                            idx          <= nxt_idx_c;
                            bus.out_data <= buf_data_c;
                            bus.out_last <= (nxt_idx_c == LAST_IDX);
                        end
                    end
                end
                ST_DONE: begin
                    busy       <= 1'b0;
                    bus.dma_rw <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_block_fetcher.sv
// Self-checking bench: two fetchers (READ_LATENCY 1 and 3), table of fetch vectors, word scoreboard.
module tb_dma_block_fetcher;
    import cnn_pkg::*;

    localparam int RL_A = 1;
    localparam int RL_B = 3;

    logic  clk = 1'b0;
    always #5 clk = ~clk;

    logic  rst;
    logic  start;
    logic  sel;
    logic  ready;
    addr_t base_addr;
    logic  start_a, start_b, busy_a, busy_b, done_a, done_b;
`ifdef DMA_BLOCK_FETCHER_SUM_EN
    logic signed [SUM_WIDTH-1:0] sum_a, sum_b;
`endif

    dma_block_fetcher_if bus_a ();
    dma_block_fetcher_if bus_b ();

    assign start_a = start && !sel;
    assign start_b = start && sel;
    assign bus_a.out_ready = ready;
    assign bus_b.out_ready = ready;

    dma_block_fetcher #(.READ_LATENCY(RL_A)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .start     (start_a),
        .base_addr (base_addr),
        .busy      (busy_a),
        .done      (done_a),
`ifdef DMA_BLOCK_FETCHER_SUM_EN
        .block_sum (sum_a),
`endif
        .bus       (bus_a.master)
    );

    dma_block_fetcher #(.READ_LATENCY(RL_B)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .start     (start_b),
        .base_addr (base_addr),
        .busy      (busy_b),
        .done      (done_b),
`ifdef DMA_BLOCK_FETCHER_SUM_EN
        .block_sum (sum_b),
`endif
        .bus       (bus_b.master)
    );

    // Monitor view of whichever fetcher is under test.
    logic  m_en, m_rw, m_valid, m_last, m_busy, m_done;
    addr_t m_addr;
    data_t m_data;
    assign m_en    = sel ? bus_b.dma_enable  : bus_a.dma_enable;
    assign m_rw    = sel ? bus_b.dma_rw      : bus_a.dma_rw;
    assign m_addr  = sel ? bus_b.dma_address : bus_a.dma_address;
    assign m_valid = sel ? bus_b.out_valid   : bus_a.out_valid;
    assign m_last  = sel ? bus_b.out_last    : bus_a.out_last;
    assign m_data  = sel ? bus_b.out_data    : bus_a.out_data;
    assign m_busy  = sel ? busy_b : busy_a;
    assign m_done  = sel ? done_b : done_a;

    data_t blk [BLOCK_SIZE];
    int    lat_a, lat_b;

    function automatic block_t pack_blk();
        block_t b;
        for (int i = 0; i < int'(BLOCK_SIZE); i++) b[i*DATA_WIDTH +: DATA_WIDTH] = blk[i];
        return b;
    endfunction

    // DMA model: block becomes stable READ_LATENCY edges after enable is sampled.
    always @(posedge clk) begin
        if (bus_a.dma_enable) begin
            if (RL_A == 1) bus_a.dma_block <= pack_blk();
            else begin bus_a.dma_block <= {BLOCK_SIZE{16'hDEAD}}; lat_a <= RL_A - 1; end
        end else if (lat_a > 0) begin
            lat_a <= lat_a - 1;
            if (lat_a == 1) bus_a.dma_block <= pack_blk();
        end
        if (bus_b.dma_enable) begin
            if (RL_B == 1) bus_b.dma_block <= pack_blk();
            else begin bus_b.dma_block <= {BLOCK_SIZE{16'hDEAD}}; lat_b <= RL_B - 1; end
        end else if (lat_b > 0) begin
            lat_b <= lat_b - 1;
            if (lat_b == 1) bus_b.dma_block <= pack_blk();
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic  sel;
        addr_t addr;
        int    kind;
        int    rmode;
        logic  inject;
        int    abort_after;
    } vec_t;

    data_t  exp_q [$];
    longint exp_sum;

    function automatic void build_block(input int kind);
        exp_sum = 0;
        for (int i = 0; i < int'(BLOCK_SIZE); i++) begin
            case (kind)
                0: blk[i] = data_t'(16'h0400 + i);
                1: blk[i] = (i % 3 == 0) ? data_t'(16'hF000) :
                            (i % 3 == 1) ? data_t'(16'hE800) : data_t'(i * 37);
                2: blk[i] = (i == 0) ? data_t'(5) : (i == 1) ? data_t'(3) :
                            (i == 2) ? data_t'(8) : data_t'(0);
                3: blk[i] = data_t'(16'hF000);
                default: blk[i] = data_t'($urandom);
            endcase
            exp_sum += longint'(blk[i]);
            exp_q.push_back(blk[i]);
        end
    endfunction

    task automatic run_fetch(input vec_t v);
        int   rl, n, beats, first_valid, en_cnt, done_cnt, last_n;
        logic stalled, held_last;
        data_t held, e;
        sel = v.sel;
        rl = v.sel ? RL_B : RL_A;
        exp_q.delete();
        build_block(v.kind);
        @(negedge clk);
        base_addr = v.addr;
        ready = 1'b1;
        start = 1'b1;
        n = 0; beats = 0; first_valid = -1; en_cnt = 0; done_cnt = 0; last_n = -1;
        stalled = 1'b0; held = '0; held_last = 1'b0;
        while (n < 400) begin
            @(negedge clk);
            n++;
            start = 1'b0;
            if (m_en) begin
                en_cnt++;
                chk("enable_cycle", 64'(n), 64'd1);
                chk("enable_rw", 64'(m_rw), 64'd1);
                chk("enable_addr", 64'(m_addr), 64'(v.addr));
            end
            if (m_busy) begin
                chk("busy_rw", 64'(m_rw), 64'd1);
                chk("busy_addr_hold", 64'(m_addr), 64'(v.addr));
            end
            if (m_valid && first_valid < 0) begin
                first_valid = n;
                chk("first_valid_latency", 64'(n), 64'(rl + 2));
            end
            if (stalled) begin
                chk("stall_valid", 64'(m_valid), 64'd1);
                chk("stall_data", 64'(m_data), 64'(held));
                chk("stall_last", 64'(m_last), 64'(held_last));
                stalled = 1'b0;
            end
            if (m_done) begin
                done_cnt++;
                chk("done_timing", 64'(n), 64'(last_n + 1));
`ifdef DMA_BLOCK_FETCHER_SUM_EN
                chk("block_sum", 64'(sel ? sum_b : sum_a), 64'(exp_sum));
`endif
            end
            if (last_n >= 0 && n == last_n + 2) begin
                chk("busy_clear", 64'(m_busy), 64'd0);
                break;
            end
            if (v.abort_after != 0 && beats == v.abort_after) begin
                rst = 1'b1;
                @(negedge clk);
                chk("abort_valid", 64'(m_valid), 64'd0);
                chk("abort_busy", 64'(m_busy), 64'd0);
                chk("abort_done", 64'(m_done | (done_cnt != 0)), 64'd0);
                chk("abort_enable", 64'(m_en), 64'd0);
                rst = 1'b0;
                exp_q.delete();
                return;
            end
            if (v.inject && n == 10) begin
                base_addr = 16'h0100;
                start = 1'b1;
            end
            ready = (v.rmode == 0) ? 1'b1 : (n % 3 == 0);
            if (m_busy) chk("busy_during_fetch", 64'(m_busy), 64'd1);
            if (m_valid) begin
                if (ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL extra_beat: got %0h expected none", m_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_data", 64'(m_data), 64'(e));
                        chk("beat_last", 64'(m_last), 64'(beats == int'(BLOCK_SIZE) - 1));
                    end
                    beats++;
                    if (beats == int'(BLOCK_SIZE)) last_n = n;
                end else begin
                    stalled = 1'b1;
                    held = m_data;
                    held_last = m_last;
                end
            end
        end
        start = 1'b0;
        ready = 1'b1;
        chk("fetch_complete", 64'(done_cnt), 64'd1);
        chk("beat_count", 64'(beats), 64'(BLOCK_SIZE));
        chk("enable_count", 64'(en_cnt), 64'd1);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    endtask

    vec_t vecs [9];

    initial begin
        vecs[0] = '{1'b0, 16'h0000, 0, 0, 1'b0, 0};   // basic fetch
        vecs[1] = '{1'b0, 16'h0040, 4, 1, 1'b0, 0};   // backpressure
        vecs[2] = '{1'b0, 16'h0000, 0, 0, 1'b1, 0};   // start while busy
        vecs[3] = '{1'b0, 16'h0200, 4, 0, 1'b0, 10};  // reset mid-stream
        vecs[4] = '{1'b0, 16'h0300, 0, 0, 1'b0, 0};   // clean fetch after abort
        vecs[5] = '{1'b1, 16'h1234, 1, 0, 1'b0, 0};   // latency 3, signed data
        vecs[6] = '{1'b1, 16'h00AA, 1, 1, 1'b0, 0};   // latency 3 with stalls
        vecs[7] = '{1'b0, 16'h0010, 2, 0, 1'b0, 0};   // small-sum block
        vecs[8] = '{1'b0, 16'h0020, 3, 0, 1'b0, 0};   // all 0xF000

        rst = 1'b1; start = 1'b0; sel = 1'b0; ready = 1'b1; base_addr = '0;
        lat_a = 0; lat_b = 0;
        bus_a.dma_block = '0; bus_b.dma_block = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'({busy_a, busy_b}), 64'd0);
        chk("rst_done", 64'({done_a, done_b}), 64'd0);
        chk("rst_dma", 64'({bus_a.dma_enable, bus_a.dma_rw, bus_b.dma_enable, bus_b.dma_rw}), 64'd0);
        chk("rst_addr", 64'({bus_a.dma_address, bus_b.dma_address}), 64'd0);
        chk("rst_out", 64'({bus_a.out_valid, bus_a.out_last, bus_a.out_data,
                            bus_b.out_valid, bus_b.out_last, bus_b.out_data}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 9; k++) begin
            run_fetch(vecs[k]);
            if (k == 1) begin
                repeat (3) @(negedge clk);
                chk("idle_addr_hold", 64'(m_addr), 64'h0040);
                chk("idle_enable", 64'(m_en), 64'd0);
                chk("idle_rw", 64'(m_rw), 64'd0);
            end
            if (k == 3) begin
                chk("post_abort_rw", 64'(m_rw), 64'd0);
                chk("post_abort_addr", 64'(m_addr), 64'd0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
